// File: rtl/slt_serial_cmp_if.sv
// Request/response bundle for the bit-serial set-less-than comparator.
interface slt_serial_cmp_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             less;
  logic             eq;
  logic             busy;

  modport master (
    output req_valid, a, b, is_signed, rsp_ready,
    input  req_ready, rsp_valid, less, eq, busy
  );

  modport slave (
    input  req_valid, a, b, is_signed, rsp_ready,
    output req_ready, rsp_valid, less, eq, busy
  );
endinterface

// File: rtl/slt_serial_cmp.sv
// Bit-serial A<B / A==B comparator, LSB-first, DIGIT bits per cycle.
// Signed compares are compiled in only when SLT_SIGNED_EN is defined.
module slt_serial_cmp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  slt_serial_cmp_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [CW-1:0]    cnt_r;
  logic             lt_r;
  logic             eqf_r;
  logic             less_r;
  logic             eq_r;
  logic             rsp_valid_r;
  logic             busy_r;
  logic             sgn_s;
  logic             last_s;
  logic             lt_s;
  logic             eqf_s;
  logic             accept_s;

`ifdef SLT_SIGNED_EN
  logic sgn_r;

  // Latch the requested signedness at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_r <= 1'b0;
    end else if (accept_s) begin
      sgn_r <= bus.is_signed;
    end else begin
      sgn_r <= sgn_r;
    end
  end

  assign sgn_s = sgn_r;
`else
  logic unused_is_signed_s;
  assign unused_is_signed_s = bus.is_signed;
  assign sgn_s              = 1'b0;
`endif

  assign bus.req_ready = (state_r == IDLE) && !rst;
  assign accept_s      = bus.req_valid && (state_r == IDLE) && !rst;
  assign last_s        = (cnt_r == LAST);

  // Fold the current digit into the running less/equal flags; higher bits win.
  always_comb begin
    lt_s  = lt_r;
    eqf_s = eqf_r;
    for (int j = 0; j < DIGIT; j++) begin
      if (sa_r[j] != sb_r[j]) begin
        eqf_s = 1'b0;
        // On the sign bit a set A bit means A is the negative (smaller) one.
        if (sgn_s && last_s && (j == DIGIT - 1)) begin
          lt_s = sa_r[j];
        end else begin
          lt_s = sb_r[j];
        end
      end else begin
        eqf_s = eqf_s;
      end
    end
  end

  // Control FSM, operand shifters and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sa_r        <= '0;
      sb_r        <= '0;
      cnt_r       <= '0;
      lt_r        <= 1'b0;
      eqf_r       <= 1'b1;
      less_r      <= 1'b0;
      eq_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            sa_r    <= bus.a;
            sb_r    <= bus.b;
            cnt_r   <= '0;
            lt_r    <= 1'b0;
            eqf_r   <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          lt_r  <= lt_s;
          eqf_r <= eqf_s;
          sa_r  <= sa_r >> DIGIT;
          sb_r  <= sb_r >> DIGIT;
          if (last_s) begin
            less_r      <= lt_s;
            eq_r        <= eqf_s;
            rsp_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            less_r      <= 1'b0;
            eq_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          less_r      <= 1'b0;
          eq_r        <= 1'b0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.less      = less_r;
  assign bus.eq        = eq_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_slt_serial_cmp.sv
// Randomized self-checking bench for slt_serial_cmp against an arithmetic model.
module tb_slt_serial_cmp;
  localparam int W   = 16;
  localparam int D   = 1;
  localparam int LAT = W / D;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  slt_serial_cmp_if #(.WIDTH(W)) bus ();

  slt_serial_cmp #(.WIDTH(W), .DIGIT(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_less(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
`ifdef SLT_SIGNED_EN
    if (s) return $signed(a) < $signed(b);
`endif
    return a < b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; wait for response; hold it 'hold' cycles (0 = ready already high).
  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
    int   n;
    logic l0, e0;
    bus.rsp_ready = (hold == 0);
    bus.req_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.is_signed = s;
    check("req_ready_idle", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.is_signed = 1'($urandom);
    check("busy_run", bus.busy, 1);
    n = 0;
    while (!bus.rsp_valid && n < 4 * LAT) begin
      tick();
      n++;
    end
    check("latency", n, LAT);
    check("less", bus.less, model_less(a, b, s));
    check("eq", bus.eq, a == b);
    l0 = bus.less;
    e0 = bus.eq;
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      tick();
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_less", bus.less, l0);
      check("hold_eq", bus.eq, e0);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("consumed_valid", bus.rsp_valid, 0);
    check("consumed_outs", {bus.less, bus.eq, bus.busy}, 0);
    check("ready_after", bus.req_ready, 1);
  endtask

  // Start a request, then reset after 'wait_cyc' cycles; no response may follow.
  task automatic abort_cmp(input int wait_cyc);
    int stray;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.a = 16'd1;
    bus.b = 16'd9;
    bus.is_signed = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < wait_cyc; i++) tick();
    rst = 1'b1;
    tick();
    check("abort_outs", {bus.rsp_valid, bus.less, bus.eq, bus.busy}, 0);
    check("abort_req_ready", bus.req_ready, 0);
    rst = 1'b0;
    #1;
    check("abort_ready_after", bus.req_ready, 1);
    stray = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (bus.rsp_valid || bus.busy) stray++;
    end
    check("abort_no_rsp", stray, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.is_signed = 1'b0;
    tick();
    tick();
    check("rst_outs", {bus.rsp_valid, bus.less, bus.eq, bus.busy}, 0);
    check("rst_req_ready", bus.req_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", bus.req_ready, 1);

    do_cmp(16'd4, 16'd5, 1'b0, 1);
    do_cmp(16'd4, 16'd1, 1'b0, 0);
    do_cmp(16'hFFFF, 16'd1, 1'b1, 2);
    do_cmp(16'hFFFF, 16'd1, 1'b0, 0);
    do_cmp(16'h8000, 16'h8000, 1'b1, 1);
    do_cmp(16'h8000, 16'h8000, 1'b0, 0);
    do_cmp(16'h8000, 16'h7FFF, 1'b1, 0);
    do_cmp(16'h7FFF, 16'h8000, 1'b0, 5);
    do_cmp(16'h0000, 16'hFFFF, 1'b1, 0);

    abort_cmp(8);
    do_cmp(16'd2, 16'd3, 1'b0, 0);
    abort_cmp(LAT + 2);
    do_cmp(16'd3, 16'd2, 1'b0, 1);

    for (int k = 0; k < 30; k++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      do_cmp(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
